// File: rtl/slave_serial_port.sv
// slave_serial_port: slave-side responder for the serial master protocol.
// Deserialises address/burst/write data (LSB first), drives a synchronous
// parallel memory port, and serialises read data back with valid/ready.
module slave_serial_port #(
  parameter int ADDR_LEN     = 12,
  parameter int DATA_LEN     = 8,
  parameter int BURST_LEN    = 12,
  parameter int MEM_ADDR_LEN = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    read_en,
  input  logic                    write_en,
  input  logic                    master_valid,
  input  logic                    master_ready,
  input  logic                    rx_address,
  input  logic                    rx_burst,
  input  logic                    rx_data,
  output logic                    slave_valid,
  output logic                    slave_ready,
  output logic                    tx_data,
  output logic                    split_en,
  output logic                    busy,
  output logic [MEM_ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0]     mem_wdata,
  output logic                    mem_we,
  output logic                    mem_re,
  input  logic [DATA_LEN-1:0]     mem_rdata
);

  localparam int MAX_LEN = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
  localparam int CW      = $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0]        ADDR_LAST  = CW'(ADDR_LEN - 1);
  localparam logic [CW-1:0]        DATA_LAST  = CW'(DATA_LEN - 1);
  localparam logic [CW-1:0]        BURST_BITS = CW'(BURST_LEN);
  localparam logic [BURST_LEN-1:0] BEAT_ONE   = BURST_LEN'(1);

  // S_RCAP is the cycle in which the memory presents the data requested in S_RMEM.
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WMEM, S_RMEM, S_RCAP, S_RDATA
  } state_e;

  state_e                  state_q, state_d;
  logic                    is_write_q, is_write_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [ADDR_LEN-1:0]     addr_sh_q, addr_sh_d;
  logic [BURST_LEN-1:0]    burst_sh_q, burst_sh_d;
  logic [BURST_LEN-1:0]    beats_q, beats_d;
  logic [MEM_ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_LEN-1:0]     wdata_q, wdata_d;
  logic [DATA_LEN-1:0]     rdata_q, rdata_d;
  logic                    slave_ready_q, slave_ready_d;
  logic                    slave_valid_q, slave_valid_d;
  logic                    mem_we_q, mem_we_d;
  logic                    mem_re_q, mem_re_d;
  logic                    busy_q, busy_d;

  // Next-state, datapath and registered-output decode for the transaction FSM.
  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    is_write_d = is_write_q;
    bit_cnt_d  = bit_cnt_q;
    addr_sh_d  = addr_sh_q;
    burst_sh_d = burst_sh_q;
    beats_d    = beats_q;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (read_en ^ write_en) begin
          is_write_d = write_en;
          bit_cnt_d  = '0;
          addr_sh_d  = '0;
          burst_sh_d = '0;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (master_valid && slave_ready_q) begin
          // NOTE: blocking assignments here let the final-bit branch below use
          // the freshly shifted addr_sh_d/burst_sh_d in the same cycle.
          addr_sh_d = {rx_address, addr_sh_q[ADDR_LEN-1:1]};
          if (bit_cnt_q < BURST_BITS) begin
            burst_sh_d = {rx_burst, burst_sh_q[BURST_LEN-1:1]};
          end
          if (bit_cnt_q == ADDR_LAST) begin
            bit_cnt_d  = '0;
            mem_addr_d = addr_sh_d[MEM_ADDR_LEN-1:0];
            beats_d    = (burst_sh_d == '0) ? BEAT_ONE : burst_sh_d;
            state_d    = is_write_q ? S_WDATA : S_RMEM;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      S_WDATA: begin
        if (master_valid && slave_ready_q) begin
          wdata_d = {rx_data, wdata_q[DATA_LEN-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_WMEM;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      S_WMEM: begin
        if (beats_q > BEAT_ONE) begin
          beats_d    = beats_q - BEAT_ONE;
          mem_addr_d = mem_addr_q + MEM_ADDR_LEN'(1);
          state_d    = S_WDATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RMEM: state_d = S_RCAP;
      S_RCAP: begin
        rdata_d = mem_rdata;
        state_d = S_RDATA;
      end
      S_RDATA: begin
        if (slave_valid_q && master_ready) begin
          rdata_d = {1'b0, rdata_q[DATA_LEN-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            if (beats_q > BEAT_ONE) begin
              beats_d    = beats_q - BEAT_ONE;
              mem_addr_d = mem_addr_q + MEM_ADDR_LEN'(1);
              state_d    = S_RMEM;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    slave_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_WDATA);
    slave_valid_d = (state_d == S_RDATA);
    mem_we_d      = (state_d == S_WMEM);
    mem_re_d      = (state_d == S_RMEM);
    busy_d        = (state_d != S_IDLE);
  end

  // State and output registers; synchronous reset aborts any transaction at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      is_write_q    <= 1'b0;
      bit_cnt_q     <= '0;
      addr_sh_q     <= '0;
      burst_sh_q    <= '0;
      beats_q       <= '0;
      mem_addr_q    <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      slave_ready_q <= 1'b1;
      slave_valid_q <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_write_q    <= is_write_d;
      bit_cnt_q     <= bit_cnt_d;
      addr_sh_q     <= addr_sh_d;
      burst_sh_q    <= burst_sh_d;
      beats_q       <= beats_d;
      mem_addr_q    <= mem_addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      slave_ready_q <= slave_ready_d;
      slave_valid_q <= slave_valid_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
      busy_q        <= busy_d;
    end
  end

  assign slave_ready = slave_ready_q;
  assign slave_valid = slave_valid_q;
  assign tx_data     = rdata_q[0];
  assign split_en    = 1'b0;
  assign busy        = busy_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;

endmodule
